reg_file_mp: RTL and testbench

- Parametrised register file: one write port and two independent read ports (A and B).
- Registered read data with a valid flag.
- Sequential clear engine that zeroes the array one entry per cycle on request, with a busy indication.
- Sits beside the ALU as operand storage; successor to the fixed 16x32 register file, with width and depth now configurable.

---
 rtl/reg_file_mp.sv | 142 ++++++++++++++
 tb/tb_reg_file_mp.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file: one write port, two registered read ports, sequential clear engine.
// Define REG_FILE_MP_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_mp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid,
    input  logic              clr_req,
    output logic              busy
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              clr_we;
    logic              wr_ok;

    logic [DATA_W-1:0] rd_a_p0, rd_b_p0;
    logic [DATA_W-1:0] rd_data_a_p1, rd_data_b_p1;
    logic              vld_p1;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < DEPTH_L;
    endfunction

    assign wr_ok = en && wr_en && (state_q == IDLE) && in_range(wr_addr);
    assign busy  = (state_q == CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Clear sweep: one entry per enabled cycle, leaving on the edge that clears the last entry.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                if (en) begin
                    clr_we = 1'b1;
                    if (ptr_q == LAST_PTR) begin
                        state_d = IDLE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Writes only happen in IDLE, so they never collide with a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (en && clr_we) begin
                mem[ptr_q] <= '0;
            end
            if (wr_ok) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    // p0: combinational array lookup
    always_comb begin
        rd_a_p0 = '0;
        rd_b_p0 = '0;
        if (in_range(rd_addr_a)) begin
            rd_a_p0 = mem[rd_addr_a];
        end
        if (in_range(rd_addr_b)) begin
            rd_b_p0 = mem[rd_addr_b];
        end
`ifdef REG_FILE_MP_BYPASS_EN
        if (wr_ok && (rd_addr_a == wr_addr)) begin
            rd_a_p0 = wr_data;
        end
        if (wr_ok && (rd_addr_b == wr_addr)) begin
            rd_b_p0 = wr_data;
        end
`endif
    end

    // p1: registered read data and valid
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            rd_data_a_p1 <= '0;
            rd_data_b_p1 <= '0;
        end else begin
            vld_p1 <= en && rd_en;
            if (en && rd_en) begin
                rd_data_a_p1 <= rd_a_p0;
                rd_data_b_p1 <= rd_b_p0;
            end
        end
    end

    assign rd_data_a = rd_data_a_p1;
    assign rd_data_b = rd_data_b_p1;
    assign rd_valid  = vld_p1;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: a 16-entry instance and a 12-entry instance share stimulus.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, wr_en, rd_en, clr_req;
    logic [3:0]  wr_addr, rd_addr_a, rd_addr_b;
    logic [31:0] wr_data;
    logic [31:0] rd_data_a, rd_data_b, rd_data_a12, rd_data_b12;
    logic        rd_valid, busy, rd_valid12, busy12;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

`ifdef REG_FILE_MP_BYPASS_EN
    localparam logic [31:0] SAME_EXP = 32'hAAAA5555;
`else
    localparam logic [31:0] SAME_EXP = 32'h0000_0001;
`endif

    reg_file_mp #(.DATA_W(32), .DEPTH(16), .ADDR_W(4)) u_dut (
        .clk(clk), .rst(rst), .en(en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid(rd_valid),
        .clr_req(clr_req), .busy(busy)
    );

    reg_file_mp #(.DATA_W(32), .DEPTH(12), .ADDR_W(4)) u_dut12 (
        .clk(clk), .rst(rst), .en(en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a12), .rd_data_b(rd_data_b12), .rd_valid(rd_valid12),
        .clr_req(clr_req), .busy(busy12)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [3:0] b,
                      input logic [31:0] ea, input logic [31:0] eb);
        rd_en     = 1'b1;
        rd_addr_a = a;
        rd_addr_b = b;
        sb_q.push_back('{a: ea, b: eb});
        tick();
        rd_en     = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("rd_valid_unexpected", 32'(rd_valid), 32'h0);
            end else begin
                mon_e = sb_q.pop_front();
                check("rd_a", rd_data_a, mon_e.a);
                check("rd_b", rd_data_b, mon_e.b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n16;
        int n12;
        rst = 1'b1; en = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
        wr_addr = '0; rd_addr_a = '0; rd_addr_b = '0; wr_data = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 32'(rd_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_data_a", rd_data_a, 32'h0);
        check("rst_busy12", 32'(busy12), 32'h0);

        // reset clears a written entry
        wr(4'd3, 32'hDEADBEEF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_valid", 32'(rd_valid), 32'h0);
        check("rst2_busy", 32'(busy), 32'h0);
        rd(4'd3, 4'd3, 32'h0, 32'h0);
        tick();

        // write then read, one-cycle valid, data hold
        wr(4'd5, 32'h12345678);
        rd(4'd5, 4'd0, 32'h12345678, 32'h0);
        check("valid_high", 32'(rd_valid), 32'h1);
        tick();
        check("valid_drop", 32'(rd_valid), 32'h0);
        check("hold_a", rd_data_a, 32'h12345678);

        // same-cycle read and write
        wr(4'd7, 32'h1);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hAAAA5555;
        rd_en = 1'b1; rd_addr_a = 4'd7; rd_addr_b = 4'd7;
        sb_q.push_back('{a: SAME_EXP, b: SAME_EXP});
        tick();
        idle();
        rd(4'd7, 4'd0, 32'hAAAA5555, 32'h0);

        // en=0 drops everything and freezes outputs
        en = 1'b0; wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h99;
        rd_en = 1'b1; rd_addr_a = 4'd5; rd_addr_b = 4'd5; clr_req = 1'b1;
        tick();
        idle();
        en = 1'b1;
        check("en0_valid", 32'(rd_valid), 32'h0);
        check("en0_hold_a", rd_data_a, 32'hAAAA5555);
        check("en0_hold_b", rd_data_b, 32'h0);
        check("en0_busy", 32'(busy), 32'h0);
        rd(4'd9, 4'd5, 32'h0, 32'h12345678);
        tick();

        // full clear sweep
        for (int i = 0; i < 16; i++) wr(4'(i), 32'hFFFFFFFF);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("sweep_busy", 32'(busy), 32'h1);
            idle();
            if (k == 2) begin
                wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h1234;
            end
            if (k == 3) begin
                rd_en = 1'b1; rd_addr_a = 4'd0; rd_addr_b = 4'd15;
                sb_q.push_back('{a: 32'h0, b: 32'hFFFFFFFF});
            end
            if (k == 5) clr_req = 1'b1;
            if (k == 6) begin
                rd_en = 1'b1; rd_addr_a = 4'd6; rd_addr_b = 4'd5;
                sb_q.push_back('{a: 32'hFFFFFFFF, b: 32'h0});
            end
            tick();
        end
        idle();
        check("sweep_done", 32'(busy), 32'h0);
        for (int i = 0; i < 16; i++) rd(4'(i), 4'(15 - i), 32'h0, 32'h0);
        tick();

        // pause mid-sweep, then reset
        for (int i = 0; i < 16; i++) wr(4'(i), 32'h100 + 32'(i));
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        tick();
        en = 1'b0; rd_en = 1'b1; rd_addr_a = 4'd4; rd_addr_b = 4'd4;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("pause_busy", 32'(busy), 32'h1);
            check("pause_valid", 32'(rd_valid), 32'h0);
        end
        rd_en = 1'b0;
        en = 1'b1;
        rd(4'd2, 4'd1, 32'h102, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_valid", 32'(rd_valid), 32'h0);
        for (int i = 0; i < 16; i++) rd(4'(i), 4'(i), 32'h0, 32'h0);
        tick();

        // non-power-of-two depth
        wr(4'd13, 32'h55);
        wr(4'd11, 32'h77);
        rd(4'd13, 4'd11, 32'h55, 32'h77);
        check("d12_oor_a", rd_data_a12, 32'h0);
        check("d12_b", rd_data_b12, 32'h77);
        check("d12_valid", 32'(rd_valid12), 32'h1);
        for (int i = 0; i < 12; i++) begin
            rd(4'(i), 4'(i), (i == 11) ? 32'h77 : 32'h0, (i == 11) ? 32'h77 : 32'h0);
            check("d12_entry", rd_data_a12, (i == 11) ? 32'h77 : 32'h0);
        end
        tick();
        n16 = 0;
        n12 = 0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (busy) n16++;
            if (busy12) n12++;
            tick();
        end
        check("busy_cycles16", 32'(n16), 32'd16);
        check("busy_cycles12", 32'(n12), 32'd12);
        check("sb_drain", 32'(sb_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
